// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the program-counter sequencer.
// State encodings are plain 3-bit constants so the state output stays legacy-compatible.
package pc_seq_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int INSTR_BYTES  = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_FETCH     = 3'd1;
    localparam state_t S_DECODE    = 3'd2;
    localparam state_t S_EXECUTE   = 3'd3;
    localparam state_t S_MEMORY    = 3'd4;
    localparam state_t S_WRITEBACK = 3'd5;
    localparam state_t S_HALT      = 3'd6;
    localparam state_t S_FAULT     = 3'd7;

    typedef struct packed {
        logic mem;
        logic branch;
        logic jump;
    } dec_info_t;

endpackage

// File: rtl/pc_seq_next.sv
// Next-PC selection and control-transfer alignment check for pc_sequencer.
// Purely combinational; the parent decides when the result is committed.
module pc_seq_next
    import pc_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            commit_take_i,
    input  logic [XLEN-1:0] commit_target_i,
    input  logic            jump_i,
    input  logic            branch_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            exec_take_o,
    output logic            misaligned_o
);

    // Sequential fetch wraps naturally at 2^XLEN through the fixed-width add.
    assign next_pc_o    = commit_take_i ? commit_target_i : (pc_i + XLEN'(INSTR_BYTES));
    assign exec_take_o  = jump_i | (branch_i & br_taken_i);
    assign misaligned_o = exec_take_o & (br_target_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer owning the PC: fetch, decode, execute, memory, writeback.
// Every output is decoded from registered state, so no input reaches an output combinationally.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             dec_mem,
    input  logic             dec_branch,
    input  logic             dec_jump,
    input  logic             dec_halt,
    input  logic             dec_illegal,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    output logic             dmem_req,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    dec_info_t        dec_q, dec_d;
    logic             take_q, take_d;
    logic [XLEN-1:0]  target_q, target_d;

    logic [XLEN-1:0]  nextPc;
    logic             execTake;
    logic             misaligned;

    pc_seq_next #(
        .XLEN(XLEN)
    ) u_next (
        .pc_i           (pc_q),
        .commit_take_i  (take_q),
        .commit_target_i(target_q),
        .jump_i         (dec_q.jump),
        .branch_i       (dec_q.branch),
        .br_taken_i     (br_taken),
        .br_target_i    (br_target),
        .next_pc_o      (nextPc),
        .exec_take_o    (execTake),
        .misaligned_o   (misaligned)
    );

    always_comb begin
        state_d  = state_q;
        dec_d    = dec_q;
        take_d   = take_q;
        target_d = target_q;
        case (state_q)
            S_IDLE:      if (run) state_d = S_FETCH;
            S_FETCH:     if (imem_ready) state_d = S_DECODE;
            S_DECODE: begin
                dec_d.mem    = dec_mem;
                dec_d.branch = dec_branch;
                dec_d.jump   = dec_jump;
                // An illegal opcode outranks a halt encoded in the same word.
                if (dec_illegal)   state_d = S_FAULT;
                else if (dec_halt) state_d = S_HALT;
                else               state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                take_d   = execTake;
                target_d = br_target;
                if (misaligned)     state_d = S_FAULT;
                else if (dec_q.mem) state_d = S_MEMORY;
                else                state_d = S_WRITEBACK;
            end
            S_MEMORY:    if (dmem_ready) state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
            default:     state_d = state_q;
        endcase
    end

    // The PC and retire count move only on the edge that ends writeback.
    assign pc_d      = (state_q == S_WRITEBACK) ? nextPc : pc_q;
    assign retired_d = (state_q == S_WRITEBACK) ? (retired_q + CNT_W'(1)) : retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            dec_q     <= '0;
            take_q    <= 1'b0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            dec_q     <= dec_d;
            take_q    <= take_d;
            target_q  <= target_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign dmem_req  = (state_q == S_MEMORY);
    assign rf_we     = (state_q == S_WRITEBACK);
    assign halted    = (state_q == S_HALT);
    assign fault     = (state_q == S_FAULT);
    assign pc        = pc_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequencing, branches, memory waits,
// PC wrap, run drop, halt/fault absorption and asynchronous reset mid-access.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic        imem_ready;
    logic [63:0] imem_addr;
    logic        dec_mem, dec_branch, dec_jump, dec_halt, dec_illegal;
    logic        br_taken;
    logic [63:0] br_target;
    logic        dmem_req;
    logic        dmem_ready;
    logic        rf_we;
    logic [63:0] pc;
    logic [2:0]  state;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    int total  = 0;
    int passed = 0;

    pc_sequencer #(
        .XLEN    (64),
        .RESET_PC(64'h0),
        .CNT_W   (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .dec_mem    (dec_mem),
        .dec_branch (dec_branch),
        .dec_jump   (dec_jump),
        .dec_halt   (dec_halt),
        .dec_illegal(dec_illegal),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .rf_we      (rf_we),
        .pc         (pc),
        .state      (state),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_mem = 0; dec_branch = 0; dec_jump = 0; dec_halt = 0; dec_illegal = 0;
        br_taken = 0; br_target = '0;
    endtask

    // Runs one instruction from IDLE to its writeback, then drops run so the core returns to IDLE.
    task automatic do_instr(input logic mem, input logic br, input logic jmp, input logic tk,
                            input logic [63:0] tgt, input int iwait, input int dwait,
                            output int cycles, output int rfw, output int ireq, output int dreq);
        int fetchK = 0;
        int memK = 0;
        bit done = 0;
        dec_mem = mem; dec_branch = br; dec_jump = jmp; br_taken = tk; br_target = tgt;
        cycles = 0; rfw = 0; ireq = 0; dreq = 0;
        run = 1; imem_ready = 1; dmem_ready = 1;
        for (int n = 0; n < 60 && !done; n++) begin
            tick();
            cycles++;
            if (rf_we)    rfw++;
            if (imem_req) ireq++;
            if (dmem_req) dreq++;
            if (state == S_FETCH) begin
                fetchK++;
                imem_ready = (fetchK > iwait);
            end else imem_ready = 1;
            if (state == S_MEMORY) begin
                memK++;
                dmem_ready = (memK > dwait);
            end else dmem_ready = 1;
            if (state == S_WRITEBACK) begin
                done = 1;
                run = 0;
            end
        end
        total++;
        if (!done) $display("[TB] FAIL instr_timeout: state=%0d never reached writeback (required %0d)", state, S_WRITEBACK);
        else passed++;
        tick();
        clear_dec();
    endtask

    task automatic wait_state(input logic [2:0] s, output bit ok, output int rfw);
        ok = 0; rfw = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick();
            if (rf_we) rfw++;
            if (state == s) ok = 1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1; run = 0; clear_dec();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; run = 0; imem_ready = 0; dmem_ready = 0; clear_dec();
        tick(); tick();
        total++; if (state !== S_IDLE) $display("[TB] FAIL reset_state: got %0d expected %0d", state, S_IDLE); else passed++;
        total++; if (pc !== 64'h0) $display("[TB] FAIL reset_pc: got %0h expected 0", pc); else passed++;
        total++; if (retired !== 32'd0) $display("[TB] FAIL reset_retired: got %0d expected 0", retired); else passed++;
        total++;
        if ({imem_req, dmem_req, rf_we, halted, fault} !== 5'b0)
            $display("[TB] FAIL reset_strobes: got %b expected 00000", {imem_req, dmem_req, rf_we, halted, fault});
        else passed++;
        reset = 0;
        tick();
        total++; if (state !== S_IDLE) $display("[TB] FAIL idle_hold: got %0d expected %0d", state, S_IDLE); else passed++;
    endtask

    task automatic test_back_to_back();
        int rfCount = 0;
        imem_ready = 1; dmem_ready = 1; clear_dec(); run = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (rf_we) rfCount++;
            total++;
            if (rf_we !== ((i % 4) == 0)) $display("[TB] FAIL b2b_rf_we cycle %0d: got %b expected %b", i, rf_we, (i % 4) == 0);
            else passed++;
            if ((i % 4) == 1) begin
                total++;
                if (!(imem_req === 1'b1 && imem_addr === 64'((i / 4) * 4)))
                    $display("[TB] FAIL b2b_fetch cycle %0d: got req=%b addr=%0h expected req=1 addr=%0h", i, imem_req, imem_addr, (i / 4) * 4);
                else passed++;
            end
        end
        run = 0;
        tick();
        total++; if (state !== S_IDLE) $display("[TB] FAIL b2b_idle: got %0d expected %0d", state, S_IDLE); else passed++;
        total++; if (pc !== 64'hC) $display("[TB] FAIL b2b_pc: got %0h expected c", pc); else passed++;
        total++; if (retired !== 32'd3 || rfCount != 3) $display("[TB] FAIL b2b_retired: got %0d/%0d expected 3/3", retired, rfCount); else passed++;
    endtask

    task automatic test_branch();
        int c, rw, ir, dr;
        do_instr(0, 0, 0, 0, 64'h0, 0, 0, c, rw, ir, dr);
        total++; if (pc !== 64'h10) $display("[TB] FAIL seq_to_10: got %0h expected 10", pc); else passed++;
        do_instr(0, 1, 0, 0, 64'h80, 0, 0, c, rw, ir, dr);
        total++; if (pc !== 64'h14) $display("[TB] FAIL branch_not_taken: got %0h expected 14", pc); else passed++;
        total++; if (c != 4) $display("[TB] FAIL branch_latency: got %0d expected 4", c); else passed++;
        do_instr(0, 0, 1, 0, 64'h10, 0, 0, c, rw, ir, dr);
        total++; if (pc !== 64'h10) $display("[TB] FAIL jump: got %0h expected 10", pc); else passed++;
        do_instr(0, 1, 0, 1, 64'h40, 0, 0, c, rw, ir, dr);
        total++; if (pc !== 64'h40) $display("[TB] FAIL branch_taken: got %0h expected 40", pc); else passed++;
        total++; if (retired !== 32'd7 || rw != 1) $display("[TB] FAIL branch_retired: got %0d rf=%0d expected 7 rf=1", retired, rw); else passed++;
    endtask

    task automatic test_memory();
        int c, rw, ir, dr;
        do_instr(1, 0, 0, 0, 64'h0, 0, 3, c, rw, ir, dr);
        total++; if (c != 8) $display("[TB] FAIL load_wait_latency: got %0d expected 8", c); else passed++;
        total++; if (dr != 4) $display("[TB] FAIL load_dmem_req_cycles: got %0d expected 4", dr); else passed++;
        total++; if (pc !== 64'h44 || rw != 1) $display("[TB] FAIL load_commit: got pc=%0h rf=%0d expected pc=44 rf=1", pc, rw); else passed++;
        do_instr(1, 0, 0, 0, 64'h0, 0, 0, c, rw, ir, dr);
        total++; if (c != 5 || dr != 1) $display("[TB] FAIL load_fast: got cycles=%0d req=%0d expected 5/1", c, dr); else passed++;
        do_instr(0, 0, 0, 0, 64'h0, 2, 0, c, rw, ir, dr);
        total++; if (c != 6 || ir != 3) $display("[TB] FAIL fetch_wait: got cycles=%0d req=%0d expected 6/3", c, ir); else passed++;
        total++; if (pc !== 64'h4C || retired !== 32'd10) $display("[TB] FAIL memory_pc: got pc=%0h ret=%0d expected 4c/10", pc, retired); else passed++;
    endtask

    task automatic test_wrap();
        int c, rw, ir, dr;
        do_instr(0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, c, rw, ir, dr);
        total++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("[TB] FAIL jump_top: got %0h expected fffffffffffffffc", pc); else passed++;
        do_instr(0, 0, 0, 0, 64'h0, 0, 0, c, rw, ir, dr);
        total++; if (pc !== 64'h0) $display("[TB] FAIL pc_wrap: got %0h expected 0", pc); else passed++;
    endtask

    task automatic test_run_drop();
        bit ok;
        int rw;
        imem_ready = 1; dmem_ready = 1; clear_dec(); run = 1;
        wait_state(S_EXECUTE, ok, rw);
        total++; if (!ok) $display("[TB] FAIL run_drop_reach_exec: got state %0d expected %0d", state, S_EXECUTE); else passed++;
        run = 0;
        tick();
        total++; if (state !== S_WRITEBACK || rf_we !== 1'b1) $display("[TB] FAIL run_drop_wb: got state=%0d rf=%b expected 5/1", state, rf_we); else passed++;
        tick();
        total++; if (state !== S_IDLE || pc !== 64'h4 || retired !== 32'd13) $display("[TB] FAIL run_drop_commit: got state=%0d pc=%0h ret=%0d expected 0/4/13", state, pc, retired); else passed++;
        repeat (3) tick();
        total++; if (state !== S_IDLE || imem_req !== 1'b0) $display("[TB] FAIL run_drop_no_fetch: got state=%0d req=%b expected 0/0", state, imem_req); else passed++;
    endtask

    task automatic test_fault();
        bit ok;
        int rw;
        imem_ready = 1; dmem_ready = 1; clear_dec();
        dec_jump = 1; br_target = 64'h42; run = 1;
        wait_state(S_FAULT, ok, rw);
        total++; if (!ok || fault !== 1'b1 || halted !== 1'b0) $display("[TB] FAIL misaligned_fault: got state=%0d fault=%b expected 7/1", state, fault); else passed++;
        total++; if (pc !== 64'h4 || rw != 0 || retired !== 32'd13) $display("[TB] FAIL fault_no_commit: got pc=%0h rf=%0d ret=%0d expected 4/0/13", pc, rw, retired); else passed++;
        repeat (4) tick();
        total++; if (state !== S_FAULT || pc !== 64'h4) $display("[TB] FAIL fault_absorb: got state=%0d pc=%0h expected 7/4", state, pc); else passed++;
        pulse_reset();
    endtask

    task automatic test_halt();
        imem_ready = 1; dmem_ready = 1; clear_dec();
        dec_halt = 1; run = 1;
        repeat (3) tick();
        total++; if (halted !== 1'b1 || state !== S_HALT || pc !== 64'h0) $display("[TB] FAIL halt: got halted=%b state=%0d pc=%0h expected 1/6/0", halted, state, pc); else passed++;
        repeat (4) tick();
        total++; if (halted !== 1'b1 || imem_req !== 1'b0 || retired !== 32'd0) $display("[TB] FAIL halt_absorb: got halted=%b req=%b ret=%0d expected 1/0/0", halted, imem_req, retired); else passed++;
        pulse_reset();
        dec_halt = 1; dec_illegal = 1; run = 1;
        repeat (3) tick();
        total++; if (fault !== 1'b1 || halted !== 1'b0) $display("[TB] FAIL illegal_priority: got fault=%b halted=%b expected 1/0", fault, halted); else passed++;
        pulse_reset();
        total++; if (state !== S_IDLE || fault !== 1'b0) $display("[TB] FAIL reset_exit: got state=%0d fault=%b expected 0/0", state, fault); else passed++;
    endtask

    task automatic test_reset_mid_memory();
        int c, rw, ir, dr;
        bit ok;
        do_instr(0, 0, 0, 0, 64'h0, 0, 0, c, rw, ir, dr);
        dec_mem = 1; run = 1; imem_ready = 1; dmem_ready = 0;
        wait_state(S_MEMORY, ok, rw);
        total++; if (!ok || dmem_req !== 1'b1) $display("[TB] FAIL mem_req_before_reset: got state=%0d req=%b expected 4/1", state, dmem_req); else passed++;
        #2 reset = 1;
        #1;
        total++;
        if (state !== S_IDLE || pc !== 64'h0 || retired !== 32'd0 || {imem_req, dmem_req, rf_we, halted, fault} !== 5'b0)
            $display("[TB] FAIL async_reset: got state=%0d pc=%0h ret=%0d strobes=%b expected 0/0/0/00000",
                     state, pc, retired, {imem_req, dmem_req, rf_we, halted, fault});
        else passed++;
        run = 0; clear_dec();
        tick();
        reset = 0;
        tick();
        total++; if (state !== S_IDLE || dmem_req !== 1'b0) $display("[TB] FAIL post_reset_idle: got state=%0d req=%b expected 0/0", state, dmem_req); else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_branch();
        test_memory();
        test_wrap();
        test_run_drop();
        test_fault();
        test_halt();
        test_reset_mid_memory();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
